shared_vc_bank_client: RTL and testbench

//  Per-input-port consumer of the shared-memory-bank grant protocol. Takes each bank's grant bit
//  for this port and its ready_for_allocation flag, and hands shared VCs from granted banks to the

---
 rtl/shared_vc_bank_client_pkg.sv | 30 +++
 rtl/shared_vc_bank_client_if.sv | 47 ++++
 rtl/shared_vc_bank_select.sv | 72 +++++++
 rtl/shared_vc_bank_client.sv | 122 ++++++++++++
 tb/tb_shared_vc_bank_client.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_vc_bank_client_pkg.sv
// Shared definitions for the shared-VC bank client: held/free VC encodings
// and the width helpers used to size the per-bank occupancy counters.
package shared_vc_bank_client_pkg;

    localparam logic VC_HELD = 1'b1;
    localparam logic VC_FREE = 1'b0;

    // Ceiling log2; clogb(1) is 0.
    function automatic int clogb(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Bits needed to count 0..nvb held VCs in one bank.
    function automatic int count_width(input int nvb);
        return clogb(nvb + 1);
    endfunction

    // Pointer width that never collapses to zero bits.
    function automatic int ptr_width(input int n);
        return (clogb(n) > 0) ? clogb(n) : 1;
    endfunction

endpackage

// File: rtl/shared_vc_bank_client_if.sv
// Bank-grant / VC-allocation bundle between one router input port and the
// shared memory banks. slave = client side, master = banks + VC allocator.
interface shared_vc_bank_client_if
    import shared_vc_bank_client_pkg::*;
#(
    parameter int num_ports = 5,
    parameter int num_vcs   = 10
);

    localparam int nvb   = num_vcs / num_ports;
    localparam int occ_w = num_ports * count_width(nvb);

    logic [num_ports-1:0] bank_grant;
    logic [num_ports-1:0] bank_ready;
    logic                 alloc_req;
    logic [num_vcs-1:0]   release_vc;
    logic                 alloc_gnt;
    logic [num_vcs-1:0]   alloc_vc;
    logic [num_vcs-1:0]   allocated_shared_ivc;
    logic [occ_w-1:0]     bank_occupancy;
    logic                 protocol_error;

    modport master (
        output bank_grant,
        output bank_ready,
        output alloc_req,
        output release_vc,
        input  alloc_gnt,
        input  alloc_vc,
        input  allocated_shared_ivc,
        input  bank_occupancy,
        input  protocol_error
    );

    modport slave (
        input  bank_grant,
        input  bank_ready,
        input  alloc_req,
        input  release_vc,
        output alloc_gnt,
        output alloc_vc,
        output allocated_shared_ivc,
        output bank_occupancy,
        output protocol_error
    );

endinterface

// File: rtl/shared_vc_bank_select.sv
// Combinational pick: rotating-priority scan of eligible banks starting at
// rr_ptr, then the lowest-index free VC of the chosen bank (one-hot).
// Ports: rr_ptr, bank_grant, bank_ready, held in; found, bank, vc_onehot out.
module shared_vc_bank_select
    import shared_vc_bank_client_pkg::*;
#(
    parameter int num_ports = 5,
    parameter int num_vcs   = 10,
    parameter int ptr_w     = 3
) (
    input  logic [ptr_w-1:0]     rr_ptr,
    input  logic [num_ports-1:0] bank_grant,
    input  logic [num_ports-1:0] bank_ready,
    input  logic [num_vcs-1:0]   held,
    output logic                 found,
    output logic [ptr_w-1:0]     bank,
    output logic [num_vcs-1:0]   vc_onehot
);

    localparam int nvb = num_vcs / num_ports;

    logic [num_vcs-1:0]   free;
    logic [num_ports-1:0] elig;

    always_comb begin
        free = '0;
        for (int v = 0; v < num_vcs; v++) begin
            free[v] = (held[v] == VC_FREE);
        end
    end

    always_comb begin
        elig = '0;
        for (int b = 0; b < num_ports; b++) begin
            elig[b] = bank_grant[b] & bank_ready[b]
                    & (|free[b*nvb +: nvb]);
        end
    end

    // First eligible bank at or after rr_ptr, wrapping modulo num_ports.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        bank  = '0;
        for (int i = 0; i < num_ports; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= num_ports) begin
                idx = idx - num_ports;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                bank  = ptr_w'(idx);
            end
        end
    end

    always_comb begin
        logic taken;
        taken     = 1'b0;
        vc_onehot = '0;
        if (found) begin
            for (int v = 0; v < nvb; v++) begin
                if (!taken && free[int'(bank)*nvb + v]) begin
                    vc_onehot[int'(bank)*nvb + v] = 1'b1;
                    taken = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/shared_vc_bank_client.sv
// Per-input-port shared-VC bank client: hands VCs from granted, ready banks
// to the VC allocator, tracks held VCs, occupancy and protocol errors.
// Ports: clk, reset (async, active-low), bus (slave side of the bundle).
module shared_vc_bank_client
    import shared_vc_bank_client_pkg::*;
#(
    parameter int num_ports = 5,
    parameter int num_vcs   = 10,
    parameter int port_id   = 0
) (
    input logic                    clk,
    input logic                    reset,
    shared_vc_bank_client_if.slave bus
);

    localparam int nvb   = num_vcs / num_ports;
    localparam int cw    = count_width(nvb);
    localparam int ptr_w = ptr_width(num_ports);

    logic [num_vcs-1:0]   held_q;
    logic [num_vcs-1:0]   held_d;
    logic [ptr_w-1:0]     rr_q;
    logic [ptr_w-1:0]     rr_d;
    logic                 gnt_q;
    logic [num_vcs-1:0]   vc_q;
    logic                 err_q;
    logic                 err_d;
    logic [num_ports-1:0] grant_q;

    logic                 found;
    logic [ptr_w-1:0]     pick_bank;
    logic [num_vcs-1:0]   pick_vc;
    logic                 take;
    logic [num_vcs-1:0]   rel_ok;
    logic [num_vcs-1:0]   rel_bad;
    logic [num_ports-1:0] bank_busy;
    logic [num_ports-1:0] grant_fell;
    logic [num_ports*cw-1:0] occ;

    shared_vc_bank_select #(
        .num_ports (num_ports),
        .num_vcs   (num_vcs),
        .ptr_w     (ptr_w)
    ) u_select (
        .rr_ptr     (rr_q),
        .bank_grant (bus.bank_grant),
        .bank_ready (bus.bank_ready),
        .held       (held_q),
        .found      (found),
        .bank       (pick_bank),
        .vc_onehot  (pick_vc)
    );

    assign take = bus.alloc_req & found;

    // Selection sees held_q, so a VC released this cycle is not reusable
    // until the next one.
    always_comb begin
        rel_ok  = bus.release_vc & held_q;
        rel_bad = bus.release_vc & ~held_q;
        held_d  = (held_q & ~rel_ok) | (take ? pick_vc : '0);
    end

    always_comb begin
        rr_d = rr_q;
        if (take) begin
            if (int'(pick_bank) == num_ports - 1) begin
                rr_d = '0;
            end else begin
                rr_d = pick_bank + ptr_w'(1);
            end
        end
    end

    // A bank dropping its grant while we still hold one of its VCs means
    // the bank allocator did not wait for drain.
    always_comb begin
        bank_busy = '0;
        for (int b = 0; b < num_ports; b++) begin
            bank_busy[b] = |held_q[b*nvb +: nvb];
        end
        grant_fell = grant_q & ~bus.bank_grant;
        err_d = err_q | (|rel_bad) | (|(grant_fell & bank_busy));
    end

    always_comb begin
        logic [cw-1:0] cnt;
        occ = '0;
        for (int b = 0; b < num_ports; b++) begin
            cnt = '0;
            for (int v = 0; v < nvb; v++) begin
                cnt = cnt + cw'(held_q[b*nvb + v]);
            end
            occ[b*cw +: cw] = cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q  <= '0;
            rr_q    <= '0;
            gnt_q   <= 1'b0;
            vc_q    <= '0;
            err_q   <= 1'b0;
            grant_q <= '0;
        end else begin
            held_q  <= held_d;
            rr_q    <= rr_d;
            gnt_q   <= take;
            vc_q    <= take ? pick_vc : '0;
            err_q   <= err_d;
            grant_q <= bus.bank_grant;
        end
    end

    assign bus.alloc_gnt            = gnt_q;
    assign bus.alloc_vc             = vc_q;
    assign bus.allocated_shared_ivc = held_q;
    assign bus.bank_occupancy       = occ;
    assign bus.protocol_error       = err_q;

endmodule

// File: tb/tb_shared_vc_bank_client.sv
// Scoreboard bench for shared_vc_bank_client: grant stream is checked by a
// monitor against a queue of expected VCs; state is checked directly.
module tb_shared_vc_bank_client;
    import shared_vc_bank_client_pkg::*;

    localparam int NP = 5;
    localparam int NV = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shared_vc_bank_client_if #(.num_ports(NP), .num_vcs(NV)) bus();

    shared_vc_bank_client #(
        .num_ports (NP),
        .num_vcs   (NV),
        .port_id   (0)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    logic [NV-1:0] exp_q[$];
    logic [NV-1:0] e;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.alloc_gnt) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL gnt_unexpected: got vc=%b, required no grant",
                             bus.alloc_vc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.alloc_vc !== e) begin
                        n_bad++;
                        $display("FAIL gnt_vc: got %b, required %b",
                                 bus.alloc_vc, e);
                    end
                end
            end else if (bus.alloc_vc !== '0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL vc_without_gnt: got %b, required 0",
                         bus.alloc_vc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d pending grants, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic release_vcs(input logic [NV-1:0] v);
        bus.release_vc = v;
        tick();
        bus.release_vc = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bank_grant = '0;
        bus.bank_ready = '0;
        bus.alloc_req  = 1'b0;
        bus.release_vc = '0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_gnt", bus.alloc_gnt, 0);
        check("rst_vc", bus.alloc_vc, 0);
        check("rst_held", bus.allocated_shared_ivc, 0);
        check("rst_occ", bus.bank_occupancy, 0);
        check("rst_err", bus.protocol_error, 0);
        rst_n = 1'b1;
        tick();

        // 1: async reset while a grant is being presented
        bus.bank_grant = 5'b00010;
        bus.bank_ready = 5'b11111;
        bus.alloc_req  = 1'b1;
        tick();
        @(posedge clk);
        #2;
        check("t1_gnt_pending", bus.alloc_gnt, 1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_gnt", bus.alloc_gnt, 0);
        check("t1_rst_vc", bus.alloc_vc, 0);
        check("t1_rst_held", bus.allocated_shared_ivc, 0);
        check("t1_rst_occ", bus.bank_occupancy, 0);
        bus.alloc_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        bus.alloc_req = 1'b1;
        exp_q.push_back(10'h004);
        tick();
        bus.alloc_req = 1'b0;
        drain("t1");
        release_vcs(10'h004);
        check("t1_held_clear", bus.allocated_shared_ivc, 0);

        // 2: bank1 fills, third request cycle gets nothing
        bus.alloc_req = 1'b1;
        exp_q.push_back(10'h004);
        tick();
        exp_q.push_back(10'h008);
        tick();
        tick();
        check("t2_no_gnt", bus.alloc_gnt, 0);
        bus.alloc_req = 1'b0;
        drain("t2");
        check("t2_held", bus.allocated_shared_ivc, 10'h00C);
        check("t2_occ", bus.bank_occupancy, 10'h008);
        release_vcs(10'h00C);
        check("t2_occ_clear", bus.bank_occupancy, 0);

        // 3: round-robin from bank0 to bank1
        do_reset();
        bus.bank_grant = 5'b00011;
        bus.alloc_req  = 1'b1;
        exp_q.push_back(10'h001);
        tick();
        exp_q.push_back(10'h004);
        tick();
        bus.alloc_req = 1'b0;
        drain("t3");
        check("t3_held", bus.allocated_shared_ivc, 10'h005);
        check("t3_occ", bus.bank_occupancy, 10'h005);
        release_vcs(10'h005);

        // 4: not-ready bank blocks new grants, held VC drains on release
        bus.bank_grant = 5'b00010;
        bus.alloc_req  = 1'b1;
        exp_q.push_back(10'h004);
        tick();
        bus.bank_ready = 5'b11101;
        tick();
        check("t4_no_gnt_a", bus.alloc_gnt, 0);
        tick();
        check("t4_no_gnt_b", bus.alloc_gnt, 0);
        bus.alloc_req = 1'b0;
        drain("t4");
        check("t4_held", bus.allocated_shared_ivc, 10'h004);
        release_vcs(10'h004);
        check("t4_held_clear", bus.allocated_shared_ivc, 0);
        bus.bank_ready = 5'b11111;

        // 5: same-cycle release and request on a full bank
        bus.alloc_req = 1'b1;
        exp_q.push_back(10'h004);
        tick();
        exp_q.push_back(10'h008);
        tick();
        bus.release_vc = 10'h004;
        tick();
        check("t5_no_gnt", bus.alloc_gnt, 0);
        check("t5_held_rel", bus.allocated_shared_ivc, 10'h008);
        bus.release_vc = '0;
        exp_q.push_back(10'h004);
        tick();
        bus.alloc_req = 1'b0;
        drain("t5");
        check("t5_held", bus.allocated_shared_ivc, 10'h00C);
        release_vcs(10'h00C);
        check("t5_occ_clear", bus.bank_occupancy, 0);

        // 6: protocol errors are sticky until reset
        bus.bank_grant = 5'b00001;
        bus.alloc_req  = 1'b1;
        exp_q.push_back(10'h001);
        tick();
        bus.alloc_req = 1'b0;
        drain("t6");
        check("t6_err_before", bus.protocol_error, 0);
        bus.bank_grant = 5'b00000;
        tick();
        check("t6_err_grant_fall", bus.protocol_error, 1);
        release_vcs(10'h001);
        check("t6_err_sticky", bus.protocol_error, 1);
        check("t6_held", bus.allocated_shared_ivc, 0);
        do_reset();
        check("t6_err_reset", bus.protocol_error, 0);
        bus.bank_grant = 5'b00001;
        tick();
        bus.bank_grant = 5'b00000;
        tick();
        tick();
        check("t6_fall_no_held", bus.protocol_error, 0);
        release_vcs(10'h080);
        check("t6_err_unheld_rel", bus.protocol_error, 1);
        check("t6_held_unchanged", bus.allocated_shared_ivc, 0);
        do_reset();
        check("t6_err_reset2", bus.protocol_error, 0);

        // rotation across all banks and wrap back to bank0
        bus.bank_grant = 5'b11111;
        bus.alloc_req  = 1'b1;
        exp_q.push_back(10'h001);
        tick();
        exp_q.push_back(10'h004);
        tick();
        exp_q.push_back(10'h010);
        tick();
        exp_q.push_back(10'h040);
        tick();
        exp_q.push_back(10'h100);
        tick();
        exp_q.push_back(10'h002);
        tick();
        bus.alloc_req = 1'b0;
        drain("wrap");
        check("wrap_held", bus.allocated_shared_ivc, 10'h157);
        check("wrap_occ", bus.bank_occupancy, 10'h156);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
